// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory port arbiter and its wait timer.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned PC_W_DEF    = 10;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2,
    DONE     = 2'd3
  } state_t;

  typedef enum logic {
    OWN_MEM = 1'b0,
    OWN_IF  = 1'b1
  } owner_t;

  // Counter width able to hold the value TIMEOUT.
  function automatic int unsigned timer_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// BUSY-cycle counter: loads 1 on entry to BUSY, counts while waiting, flags when it reaches TIMEOUT.
module wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = timer_w(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Count holds the number of the current BUSY cycle; cleared whenever not waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(1);
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_expired_c = (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences MEM-stage and fetch accesses onto one shared req/ack memory port,
// MEM first, with a stall output for the pipeline and a timeout for hung accesses.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              freeze,
  input  logic              if_req,
  input  logic [PC_W-1:0]   if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic              err
);

  state_t              r_state,     w_state_nxt;
  owner_t              r_owner,     w_owner_nxt;
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata,     w_wdata_nxt;
  logic                r_we,        w_we_nxt;
  logic                r_sram_req,  w_sram_req_nxt;
  logic                r_mem_done,  w_mem_done_nxt;
  logic                r_if_valid,  w_if_valid_nxt;
  logic [DATA_W-1:0]   r_mem_rdata, w_mem_rdata_nxt;
  logic [DATA_W-1:0]   r_if_data,   w_if_data_nxt;
  logic                r_err,       w_err_nxt;
  logic                w_tmr_start;
  logic                w_tmr_en;
  logic                w_expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk         (Clk),
    .rst         (rst),
    .i_start     (w_tmr_start),
    .i_en        (w_tmr_en),
    .o_expired_c (w_expired)
  );

  // Next-state, latched request and completion outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_we_nxt        = r_we;
    w_sram_req_nxt  = 1'b0;
    w_mem_done_nxt  = 1'b0;
    w_if_valid_nxt  = 1'b0;
    w_mem_rdata_nxt = r_mem_rdata;
    w_if_data_nxt   = r_if_data;
    w_err_nxt       = r_err;
    w_tmr_start     = 1'b0;
    w_tmr_en        = 1'b0;

    case (r_state)
      IDLE: begin
        if (mem_read || mem_write) begin
          w_state_nxt    = MEM_BUSY;
          w_owner_nxt    = OWN_MEM;
          w_addr_nxt     = mem_addr;
          w_wdata_nxt    = mem_wdata;
          w_we_nxt       = mem_write;
          w_sram_req_nxt = 1'b1;
          w_tmr_start    = 1'b1;
        end else if (if_req) begin
          w_state_nxt    = IF_BUSY;
          w_owner_nxt    = OWN_IF;
          w_addr_nxt     = ADDR_W'(if_addr);
          w_we_nxt       = 1'b0;
          w_sram_req_nxt = 1'b1;
          w_tmr_start    = 1'b1;
        end
      end

      MEM_BUSY, IF_BUSY: begin
        // Ack takes precedence over an expiry in the same cycle.
        if (sram_ack) begin
          w_state_nxt = DONE;
          if (!r_we) begin
            if (r_owner == OWN_MEM) w_mem_rdata_nxt = sram_rdata;
            else                    w_if_data_nxt   = sram_rdata;
          end
          w_mem_done_nxt = (r_owner == OWN_MEM);
          w_if_valid_nxt = (r_owner == OWN_IF);
        end else if (w_expired) begin
          w_state_nxt = DONE;
          w_err_nxt   = 1'b1;
          if (r_owner == OWN_MEM) w_mem_rdata_nxt = '0;
          else                    w_if_data_nxt   = '0;
          w_mem_done_nxt = (r_owner == OWN_MEM);
          w_if_valid_nxt = (r_owner == OWN_IF);
        end else begin
          w_sram_req_nxt = 1'b1;
          w_tmr_en       = 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_MEM;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_sram_req  <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_rdata <= '0;
      r_if_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_we        <= w_we_nxt;
      r_sram_req  <= w_sram_req_nxt;
      r_mem_done  <= w_mem_done_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_if_data   <= w_if_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign sram_req   = r_sram_req;
  assign sram_we    = r_we;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign mem_done   = r_mem_done;
  assign mem_rdata  = r_mem_rdata;
  assign if_valid   = r_if_valid;
  assign if_data    = r_if_data;
  assign err        = r_err;
  // Stall released in the completion cycle so EX/MEM advances on that edge.
  assign freeze     = (mem_read | mem_write) & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, store with waits, MEM/IF priority, timeout, reset abort.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, freeze;
  logic        if_req;
  logic [9:0]  if_addr;
  logic [15:0] if_data;
  logic        if_valid;
  logic        sram_req, sram_we;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_ack;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .DATA_W(16), .ADDR_W(16), .PC_W(10), .TIMEOUT(15)
  ) dut (
    .Clk(Clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .freeze(freeze), .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_valid(if_valid), .sram_req(sram_req), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ack(sram_ack), .err(err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    if_req = 0; if_addr = '0; sram_rdata = '0; sram_ack = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (sram_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b expected 0", sram_req); end
    n_checks++; if (mem_done !== 1'b0 || if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pulses: got %b%b expected 00", mem_done, if_valid); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (mem_rdata !== 16'h0 || if_data !== 16'h0) begin n_errors++; $display("FAIL reset_data: got %h/%h expected 0000/0000", mem_rdata, if_data); end
    n_checks++; if (sram_addr !== 16'h0 || sram_wdata !== 16'h0 || sram_we !== 1'b0) begin n_errors++; $display("FAIL reset_port: got %h/%h/%b expected 0000/0000/0", sram_addr, sram_wdata, sram_we); end
    n_checks++; if (freeze !== 1'b0) begin n_errors++; $display("FAIL reset_freeze: got %b expected 0", freeze); end
  endtask

  task automatic test_load();
    tick();
    mem_read = 1'b1; mem_addr = 16'h0040; #1;
    n_checks++; if (freeze !== 1'b1 || sram_req !== 1'b0) begin n_errors++; $display("FAIL load_c0: got freeze=%b req=%b expected 1/0", freeze, sram_req); end
    tick();
    n_checks++; if (sram_req !== 1'b1 || sram_addr !== 16'h0040 || sram_we !== 1'b0) begin n_errors++; $display("FAIL load_c1_port: got req=%b addr=%h we=%b expected 1/0040/0", sram_req, sram_addr, sram_we); end
    n_checks++; if (freeze !== 1'b1 || mem_done !== 1'b0) begin n_errors++; $display("FAIL load_c1_freeze: got freeze=%b done=%b expected 1/0", freeze, mem_done); end
    sram_ack = 1'b1; sram_rdata = 16'hBEEF;
    tick();
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL load_c2_done: got done=%b rdata=%h expected 1/beef", mem_done, mem_rdata); end
    n_checks++; if (freeze !== 1'b0 || sram_req !== 1'b0) begin n_errors++; $display("FAIL load_c2_freeze: got freeze=%b req=%b expected 0/0", freeze, sram_req); end
    sram_ack = 1'b0; mem_read = 1'b0;
    tick();
    n_checks++; if (mem_done !== 1'b0 || mem_rdata !== 16'hBEEF || sram_req !== 1'b0) begin n_errors++; $display("FAIL load_c3_hold: got done=%b rdata=%h req=%b expected 0/beef/0", mem_done, mem_rdata, sram_req); end
  endtask

  task automatic test_store_waits();
    mem_write = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'h1234; sram_rdata = 16'hFFFF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      mem_addr = 16'hDEAD; mem_wdata = 16'hCAFE;
      n_checks++; if (sram_req !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 16'h0010 || sram_wdata !== 16'h1234)
        begin n_errors++; $display("FAIL store_c%0d_port: got req=%b we=%b addr=%h wdata=%h expected 1/1/0010/1234", c, sram_req, sram_we, sram_addr, sram_wdata); end
      n_checks++; if (mem_done !== 1'b0) begin n_errors++; $display("FAIL store_c%0d_done: got %b expected 0", c, mem_done); end
      if (c == 4) sram_ack = 1'b1;
    end
    tick();
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 16'hBEEF || err !== 1'b0) begin n_errors++; $display("FAIL store_c5: got done=%b rdata=%h err=%b expected 1/beef/0", mem_done, mem_rdata, err); end
    sram_ack = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    int if_pulses;
    if_pulses = 0;
    mem_read = 1'b1; mem_addr = 16'h0020; if_req = 1'b1; if_addr = 10'h3FF;
    tick();
    n_checks++; if (sram_addr !== 16'h0020 || sram_req !== 1'b1) begin n_errors++; $display("FAIL prio_c1_mem_first: got addr=%h req=%b expected 0020/1", sram_addr, sram_req); end
    sram_ack = 1'b1; sram_rdata = 16'h5555;
    tick();
    n_checks++; if (mem_done !== 1'b1 || if_valid !== 1'b0 || mem_rdata !== 16'h5555) begin n_errors++; $display("FAIL prio_c2_done: got done=%b valid=%b rdata=%h expected 1/0/5555", mem_done, if_valid, mem_rdata); end
    sram_ack = 1'b0; mem_read = 1'b0;
    tick();
    n_checks++; if (sram_req !== 1'b0) begin n_errors++; $display("FAIL prio_c3_idle: got req=%b expected 0", sram_req); end
    tick();
    n_checks++; if (sram_req !== 1'b1 || sram_addr !== 16'h03FF || sram_we !== 1'b0) begin n_errors++; $display("FAIL prio_c4_fetch: got req=%b addr=%h we=%b expected 1/03ff/0", sram_req, sram_addr, sram_we); end
    sram_ack = 1'b1; sram_rdata = 16'hA5A5;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_data !== 16'hA5A5 || mem_done !== 1'b0 || mem_rdata !== 16'h5555)
      begin n_errors++; $display("FAIL prio_c5_valid: got valid=%b data=%h done=%b rdata=%h expected 1/a5a5/0/5555", if_valid, if_data, mem_done, mem_rdata); end
    if_pulses += int'(if_valid);
    sram_ack = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if_pulses += int'(if_valid);
    end
    n_checks++; if (if_pulses != 1) begin n_errors++; $display("FAIL prio_if_pulses: got %0d expected 1", if_pulses); end
  endtask

  task automatic test_timeout();
    mem_read = 1'b1; mem_addr = 16'h0100;
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_checks++; if (sram_req !== 1'b1 || mem_done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL timeout_busy_c%0d: got req=%b done=%b err=%b expected 1/0/0", c, sram_req, mem_done, err); end
    end
    tick();
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 16'h0 || err !== 1'b1 || sram_req !== 1'b0)
      begin n_errors++; $display("FAIL timeout_c16: got done=%b rdata=%h err=%b req=%b expected 1/0000/1/0", mem_done, mem_rdata, err, sram_req); end
    mem_read = 1'b0;
    tick(); tick();
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got %b expected 1", err); end
  endtask

  task automatic test_ack_at_limit();
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL limit_err_cleared: got %b expected 0", err); end
    mem_read = 1'b1; mem_addr = 16'h0200;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 15) begin sram_ack = 1'b1; sram_rdata = 16'h7777; end
    end
    n_checks++; if (sram_req !== 1'b1) begin n_errors++; $display("FAIL limit_c15_req: got %b expected 1", sram_req); end
    tick();
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 16'h7777 || err !== 1'b0) begin n_errors++; $display("FAIL limit_c16: got done=%b rdata=%h err=%b expected 1/7777/0", mem_done, mem_rdata, err); end
    sram_ack = 1'b0; mem_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; mem_addr = 16'h0300;
    tick();
    tick();
    n_checks++; if (sram_req !== 1'b1 || sram_addr !== 16'h0300) begin n_errors++; $display("FAIL rstmid_c2: got req=%b addr=%h expected 1/0300", sram_req, sram_addr); end
    rst = 1'b1; mem_read = 1'b0;
    tick();
    rst = 1'b0; sram_ack = 1'b1; sram_rdata = 16'h9999; #1;
    n_checks++; if (sram_req !== 1'b0 || mem_done !== 1'b0 || sram_addr !== 16'h0 || mem_rdata !== 16'h0 || err !== 1'b0)
      begin n_errors++; $display("FAIL rstmid_c3: got req=%b done=%b addr=%h rdata=%h err=%b expected 0/0/0000/0000/0", sram_req, mem_done, sram_addr, mem_rdata, err); end
    tick();
    n_checks++; if (mem_done !== 1'b0 || sram_req !== 1'b0 || mem_rdata !== 16'h0 || if_valid !== 1'b0)
      begin n_errors++; $display("FAIL rstmid_c4: got done=%b req=%b rdata=%h valid=%b expected 0/0/0000/0", mem_done, sram_req, mem_rdata, if_valid); end
    sram_ack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_waits();
    test_priority();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
